// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the system bus master and the timer register front-end.
//   psel/penable/pwrite/paddr/pwdata : master -> slave request
//   prdata/pready/pslverr            : slave -> master response
interface timer_apb_regs_if;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_regs.sv
// APB slave register front-end for the 8-bit timer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   apb               APB slave port (timer_apb_regs_if.slave)
//   start_counter     preload value (TDR)
//   up_down, enable   count direction / enable (TCR[5], TCR[4])
//   cks               prescaler select (TCR[1:0])
//   load              one-cycle load strobe (TCR[7] written as 1)
//   clr_overflow      one-cycle clear strobe (TSR[0] written as 1)
//   clr_underflow     one-cycle clear strobe (TSR[1] written as 1)
//   overflow, underflow, tcnt   live status/count from the counter
// Register map: 0x00 TDR, 0x01 TCR, 0x02 TSR (W1C), 0x03 TCNT (RO), others -> pslverr.
module timer_apb_regs #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    timer_apb_regs_if.slave      apb,
    output logic [7:0]           start_counter,
    output logic                 up_down,
    output logic                 enable,
    output logic [1:0]           cks,
    output logic                 load,
    output logic                 clr_overflow,
    output logic                 clr_underflow,
    input  logic                 overflow,
    input  logic                 underflow,
    input  logic [7:0]           tcnt
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WCNT_W = 2;

    localparam logic [DATA_W-1:0] ADDR_TDR  = 8'h00;
    localparam logic [DATA_W-1:0] ADDR_TCR  = 8'h01;
    localparam logic [DATA_W-1:0] ADDR_TSR  = 8'h02;
    localparam logic [DATA_W-1:0] ADDR_TCNT = 8'h03;

    // Reject wait-state counts the counter cannot hold
    generate
        if (WAIT_STATES > 3) begin : g_ws_check
            $error("timer_apb_regs: WAIT_STATES must be in 0..3");
        end
    endgenerate

    // The APB setup cycle is recognised while idle; ACCESS covers every penable cycle.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   tdr_q, tdr_d;
    logic                up_down_q, up_down_d;
    logic                enable_q, enable_d;
    logic [1:0]          cks_q, cks_d;
    logic                load_q, load_d;
    logic                clr_ovf_q, clr_ovf_d;
    logic                clr_udf_q, clr_udf_d;

    logic                complete_c;
    logic                addr_err_c;
    logic [DATA_W-1:0]   rd_mux_c;

    // State, wait counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            tdr_q     <= '0;
            up_down_q <= 1'b0;
            enable_q  <= 1'b0;
            cks_q     <= '0;
            load_q    <= 1'b0;
            clr_ovf_q <= 1'b0;
            clr_udf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            tdr_q     <= tdr_d;
            up_down_q <= up_down_d;
            enable_q  <= enable_d;
            cks_q     <= cks_d;
            load_q    <= load_d;
            clr_ovf_q <= clr_ovf_d;
            clr_udf_q <= clr_udf_d;
        end
    end

    // Next state: a bus violation inside ACCESS aborts straight back to IDLE
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ST_ACCESS;
                    wcnt_d  = WCNT_W'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (!apb.psel || !apb.penable) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: response is registered one cycle ahead, writes commit at end of completion
    always_comb begin
        complete_c = (state_q == ST_ACCESS) && apb.psel && apb.penable && (wcnt_q == '0);
        addr_err_c = (apb.paddr > ADDR_TCNT);

        rd_mux_c = '0;
        case (apb.paddr)
            ADDR_TDR:  rd_mux_c = tdr_q;
            ADDR_TCR:  rd_mux_c = {2'b00, up_down_q, enable_q, 2'b00, cks_q};
            ADDR_TSR:  rd_mux_c = {6'b000000, underflow, overflow};
            ADDR_TCNT: rd_mux_c = tcnt;
            default:   rd_mux_c = '0;
        endcase

        // The next cycle is the completion cycle exactly when ACCESS is entered/held with zero waits left
        pready_d  = (state_d == ST_ACCESS) && (wcnt_d == '0);
        prdata_d  = (pready_d && !apb.pwrite) ? rd_mux_c : '0;
        pslverr_d = pready_d && addr_err_c;

        tdr_d     = tdr_q;
        up_down_d = up_down_q;
        enable_d  = enable_q;
        cks_d     = cks_q;
        load_d    = 1'b0;
        clr_ovf_d = 1'b0;
        clr_udf_d = 1'b0;

        if (complete_c && apb.pwrite) begin
            case (apb.paddr)
                ADDR_TDR: tdr_d = apb.pwdata;
                ADDR_TCR: begin
                    load_d    = apb.pwdata[7];
                    up_down_d = apb.pwdata[5];
                    enable_d  = apb.pwdata[4];
                    cks_d     = apb.pwdata[1:0];
                end
                ADDR_TSR: begin
                    clr_ovf_d = apb.pwdata[0];
                    clr_udf_d = apb.pwdata[1];
                end
                default: ;
            endcase
        end
    end

    assign apb.prdata    = prdata_q;
    assign apb.pready    = pready_q;
    assign apb.pslverr   = pslverr_q;
    assign start_counter = tdr_q;
    assign up_down       = up_down_q;
    assign enable        = enable_q;
    assign cks           = cks_q;
    assign load          = load_q;
    assign clr_overflow  = clr_ovf_q;
    assign clr_underflow = clr_udf_q;
endmodule

// File: tb/tb_timer_apb_regs.sv
// Self-checking bench for timer_apb_regs: directed register-map cases plus randomized
// APB traffic; responses are checked by a scoreboard monitor against a register model.
module tb_timer_apb_regs;
    localparam int unsigned WS = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] start_counter;
    logic       up_down, enable;
    logic [1:0] cks;
    logic       load, clr_overflow, clr_underflow;
    logic       overflow = 1'b0, underflow = 1'b0;
    logic [7:0] tcnt = 8'h00;

    timer_apb_regs_if bus ();

    timer_apb_regs #(.WAIT_STATES(WS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .apb           (bus),
        .start_counter (start_counter),
        .up_down       (up_down),
        .enable        (enable),
        .cks           (cks),
        .load          (load),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
        .overflow      (overflow),
        .underflow     (underflow),
        .tcnt          (tcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
        string      name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Register model: what software should see after each completed write
    logic [7:0] m_tdr = 8'h00;
    logic [7:0] m_tcr = 8'h00;
    int         m_load_cyc = -1;
    int         m_clro_cyc = -1;
    int         m_clru_cyc = -1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Response monitor plus per-cycle comparison of the counter-side outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got pready=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_prdata"},  32'(bus.prdata),  32'(mon_e.rdata));
                    check({mon_e.name, "_pslverr"}, 32'(bus.pslverr), 32'(mon_e.err));
                    check({mon_e.name, "_cycle"},   32'(cyc),         32'(mon_e.cyc));
                end
            end else begin
                check("idle_response", {23'd0, bus.pslverr, bus.prdata}, 32'd0);
            end
            check("start_counter", 32'(start_counter), 32'(m_tdr));
            check("tcr_fields", 32'({up_down, enable, cks}),
                  32'({m_tcr[5], m_tcr[4], m_tcr[1:0]}));
            check("strobes", 32'({load, clr_overflow, clr_underflow}),
                  32'({cyc == m_load_cyc, cyc == m_clro_cyc, cyc == m_clru_cyc}));
        end
    end

    // One APB transfer starting at posedge+1; expected response computed from the model
    task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [7:0] data,
                            input string name);
        exp_t e;
        bit   done;
        int   comp;
        e.err = (addr > 8'h03);
        case (addr)
            8'h00:   e.rdata = m_tdr;
            8'h01:   e.rdata = m_tcr;
            8'h02:   e.rdata = {6'd0, underflow, overflow};
            8'h03:   e.rdata = tcnt;
            default: e.rdata = 8'h00;
        endcase
        if (wr) e.rdata = 8'h00;
        e.cyc  = cyc + 1 + int'(WS);
        e.name = name;
        sb.push_back(e);

        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = data;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        done = 1'b0;
        comp = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (bus.pready) begin
                done = 1'b1;
                comp = cyc;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no pready expected pready within 8 cycles", name);
        end
        @(posedge clk);
        if (done && wr) begin
            case (addr)
                8'h00: m_tdr = data;
                8'h01: begin
                    m_tcr = data & 8'h33;
                    if (data[7]) m_load_cyc = comp + 1;
                end
                8'h02: begin
                    if (data[0]) m_clro_cyc = comp + 1;
                    if (data[1]) m_clru_cyc = comp + 1;
                end
                default: ;
            endcase
        end
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // Setup, then psel dropped in the first ACCESS cycle: nothing may complete or change
    task automatic apb_abort(input logic [7:0] addr, input logic [7:0] data);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = addr; bus.pwdata = data;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b1;
        @(posedge clk); #1;
        bus.penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_bus"}, 32'({bus.pready, bus.pslverr, bus.prdata}), 32'd0);
        check({name, "_regs"}, 32'({start_counter, up_down, enable, cks}), 32'd0);
        check({name, "_strobes"}, 32'({load, clr_overflow, clr_underflow}), 32'd0);
    endtask

    task automatic model_reset();
        m_tdr = 8'h00; m_tcr = 8'h00;
        m_load_cyc = -1; m_clro_cyc = -1; m_clru_cyc = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, d;
        logic       w;
        int         r;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 8'h00; bus.pwdata = 8'h00;

        // Reset held for five cycles
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1);
        apb_xfer(8'h01, 1'b0, 8'h00, "rd_tcr_reset");
        apb_xfer(8'h00, 1'b0, 8'h00, "rd_tdr_reset");
        idle(1);

        // TDR write/readback, TCR write with load strobe
        apb_xfer(8'h00, 1'b1, 8'hA5, "wr_tdr");
        idle(1);
        apb_xfer(8'h00, 1'b0, 8'h00, "rd_tdr");
        idle(1);
        apb_xfer(8'h01, 1'b1, 8'hB1, "wr_tcr");
        idle(2);
        apb_xfer(8'h01, 1'b0, 8'h00, "rd_tcr");
        idle(1);

        // Status read and W1C clear strobes
        overflow = 1'b1; underflow = 1'b1;
        apb_xfer(8'h02, 1'b0, 8'h00, "rd_tsr");
        apb_xfer(8'h02, 1'b1, 8'h01, "wr_tsr_ovf");
        idle(2);
        apb_xfer(8'h02, 1'b1, 8'h02, "wr_tsr_udf");
        apb_xfer(8'h02, 1'b1, 8'h00, "wr_tsr_zero");
        idle(1);

        // Unmapped and read-only accesses
        apb_xfer(8'h07, 1'b0, 8'h00, "rd_bad");
        apb_xfer(8'h07, 1'b1, 8'hFF, "wr_bad");
        apb_xfer(8'h03, 1'b1, 8'h55, "wr_tcnt");
        idle(1);

        // Back-to-back transfers, then an aborted write
        tcnt = 8'h3C;
        apb_xfer(8'h00, 1'b1, 8'h5A, "b2b_wr");
        apb_xfer(8'h03, 1'b0, 8'h00, "b2b_rd_tcnt");
        apb_abort(8'h00, 8'hEE);
        apb_xfer(8'h00, 1'b0, 8'h00, "rd_after_abort");
        idle(1);

        // Reset in the middle of a transfer
        apb_xfer(8'h01, 1'b1, 8'h13, "wr_tcr_pre_rst");
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h77;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_reset");
        bus.psel = 1'b0; bus.penable = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        apb_xfer(8'h00, 1'b0, 8'h00, "rd_tdr_after_rst");
        idle(1);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                overflow  = 1'($urandom_range(0, 1));
                underflow = 1'($urandom_range(0, 1));
                tcnt      = 8'($urandom);
            end
            r = int'($urandom_range(0, 5));
            a = (r < 4) ? 8'(r) : 8'($urandom_range(4, 255));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                apb_abort(a, d);
            end else begin
                apb_xfer(a, w, d, w ? "rnd_wr" : "rnd_rd");
            end
            idle(int'($urandom_range(0, 2)));
        end

        idle(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
